// File: rtl/ctrl_fac_seq.sv
// ctrl_fac_seq: parametrised twiddle-multiply sequencer.
// Steps through SEL_PER_SEG select values per segment, holding each one for
// BURST cycles, over NUM_SEG segments per frame. Each segment is started by en_i.
// A single pending request lets the next segment follow with no gap.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   en_i            segment start request
//   abort_i         synchronous cancel of the current frame
//   en_mul_o        multiplier enable
//   mul_val_sel_o   twiddle/value select
//   seg_idx_o       current or most recent segment index
//   busy_o          high whenever not idle
//   seg_done_o      one-cycle pulse after each segment
//   alert_o         one-cycle pulse after the final segment of a frame
module ctrl_fac_seq #(
    parameter int BURST       = 4,
    parameter int SEL_PER_SEG = 2,
    parameter int NUM_SEG     = 2,
    localparam int SEL_W = $clog2(SEL_PER_SEG * NUM_SEG) < 1 ? 1 : $clog2(SEL_PER_SEG * NUM_SEG),
    localparam int SEG_W = $clog2(NUM_SEG) < 1 ? 1 : $clog2(NUM_SEG),
    localparam int CNT_W = $clog2(BURST) < 1 ? 1 : $clog2(BURST)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             abort_i,
    output logic             en_mul_o,
    output logic [SEL_W-1:0] mul_val_sel_o,
    output logic [SEG_W-1:0] seg_idx_o,
    output logic             busy_o,
    output logic             seg_done_o,
    output logic             alert_o
);
    localparam int SUB_W = $clog2(SEL_PER_SEG) < 1 ? 1 : $clog2(SEL_PER_SEG);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_WAIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic             pend_q, pend_d;
    logic             done_q, done_d;
    logic             alert_q, alert_d;
    logic             last_burst, seg_end, last_seg, go;

    assign last_burst = cnt_q == CNT_W'(BURST - 1);
    assign seg_end    = last_burst && sub_q == SUB_W'(SEL_PER_SEG - 1);
    assign last_seg   = seg_q == SEG_W'(NUM_SEG - 1);
    assign go         = pend_q | en_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        sel_d   = sel_q;
        seg_d   = seg_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        alert_d = 1'b0;
        if (abort_i) begin
            // abort while idle leaves the held select/segment untouched
            if (state_q != S_IDLE) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                sub_d   = '0;
                sel_d   = '0;
                seg_d   = '0;
                pend_d  = 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE: if (en_i) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                    sub_d   = '0;
                    sel_d   = '0;
                    seg_d   = '0;
                    pend_d  = 1'b0;
                end
                // sel_q still holds the last select of the previous segment,
                // so +1 lands on the first select of the next one
                S_WAIT: if (en_i) begin
                    state_d = S_ACTIVE;
                    seg_d   = seg_q + 1'b1;
                    sel_d   = sel_q + 1'b1;
                end
                default: begin
                    cnt_d = last_burst ? '0 : cnt_q + 1'b1;
                    if (last_burst && !seg_end) begin
                        sub_d = sub_q + 1'b1;
                        sel_d = sel_q + 1'b1;
                    end
                    if (en_i && !seg_end)
                        pend_d = 1'b1;
                    if (seg_end) begin
                        done_d  = 1'b1;
                        alert_d = last_seg;
                        sub_d   = '0;
                        pend_d  = 1'b0;
                        state_d = go ? S_ACTIVE : (last_seg ? S_IDLE : S_WAIT);
                        seg_d   = !go ? seg_q : (last_seg ? '0 : seg_q + 1'b1);
                        sel_d   = !go ? sel_q : (last_seg ? '0 : sel_q + 1'b1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sub_q   <= '0;
            sel_q   <= '0;
            seg_q   <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            alert_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            alert_q <= alert_d;
        end
    end

    assign en_mul_o      = state_q == S_ACTIVE;
    assign busy_o        = state_q != S_IDLE;
    assign mul_val_sel_o = sel_q;
    assign seg_idx_o     = seg_q;
    assign seg_done_o    = done_q;
    assign alert_o       = alert_q;
endmodule

// File: tb/tb_ctrl_fac_seq.sv
// tb_ctrl_fac_seq: random and directed check of ctrl_fac_seq against a cycle-position model.
module tb_ctrl_fac_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic abort = 1'b0;
    always #5 clk = ~clk;

    logic       em0, busy0, done0, al0;
    logic [1:0] sel0;
    logic       seg0;
    logic       em1, busy1, done1, al1;
    logic [1:0] sel1;
    logic       seg1;

    ctrl_fac_seq dut0 (
        .clk(clk), .rst(rst), .en_i(en), .abort_i(abort),
        .en_mul_o(em0), .mul_val_sel_o(sel0), .seg_idx_o(seg0),
        .busy_o(busy0), .seg_done_o(done0), .alert_o(al0)
    );

    ctrl_fac_seq #(.BURST(1), .SEL_PER_SEG(3), .NUM_SEG(1)) dut1 (
        .clk(clk), .rst(rst), .en_i(en), .abort_i(abort),
        .en_mul_o(em1), .mul_val_sel_o(sel1), .seg_idx_o(seg1),
        .busy_o(busy1), .seg_done_o(done1), .alert_o(al1)
    );

    // mode: 0 idle, 1 running a segment, 2 between segments
    typedef struct packed {
        int bu, sps, ns, mode, seg, p, sel;
        bit pend, done, alert;
    } model_t;

    model_t m0, m1;
    int n_vec = 0;
    int n_err = 0;

    function automatic model_t mreset(int bu, int sps, int ns);
        model_t m;
        m = '0;
        m.bu = bu;
        m.sps = sps;
        m.ns = ns;
        return m;
    endfunction

    // p is the cycle position within the segment; the select follows from it
    function automatic model_t step(model_t mi, bit e, bit a);
        model_t m;
        m = mi;
        m.done = 0;
        m.alert = 0;
        if (a) begin
            if (m.mode != 0) begin
                m.mode = 0; m.seg = 0; m.sel = 0; m.pend = 0;
            end
        end else if (m.mode == 0) begin
            if (e) begin m.mode = 1; m.seg = 0; m.p = 0; end
        end else if (m.mode == 2) begin
            if (e) begin m.mode = 1; m.seg = m.seg + 1; m.p = 0; end
        end else if (m.p == m.bu * m.sps - 1) begin
            m.done = 1;
            m.alert = (m.seg == m.ns - 1);
            if (m.pend || e) begin
                m.seg = m.alert ? 0 : m.seg + 1;
                m.p = 0;
            end else begin
                m.mode = m.alert ? 0 : 2;
            end
            m.pend = 0;
        end else begin
            m.p = m.p + 1;
            if (e) m.pend = 1;
        end
        if (m.mode == 1) m.sel = m.seg * m.sps + m.p / m.bu;
        return m;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("d0_en_mul", int'(em0), int'(m0.mode == 1));
        chk("d0_sel", int'(sel0), m0.sel);
        chk("d0_seg", int'(seg0), m0.seg);
        chk("d0_busy", int'(busy0), int'(m0.mode != 0));
        chk("d0_done", int'(done0), int'(m0.done));
        chk("d0_alert", int'(al0), int'(m0.alert));
        chk("d1_en_mul", int'(em1), int'(m1.mode == 1));
        chk("d1_sel", int'(sel1), m1.sel);
        chk("d1_seg", int'(seg1), m1.seg);
        chk("d1_busy", int'(busy1), int'(m1.mode != 0));
        chk("d1_done", int'(done1), int'(m1.done));
        chk("d1_alert", int'(al1), int'(m1.alert));
    endtask

    task automatic cyc(input bit e, input bit a);
        en = e;
        abort = a;
        @(posedge clk);
        m0 = step(m0, e, a);
        m1 = step(m1, e, a);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0);
    endtask

    initial begin
        m0 = mreset(4, 2, 2);
        m1 = mreset(1, 3, 1);
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        // two segments started separately, gap of 5 after first seg_done
        cyc(1, 0); idle(8); idle(5); cyc(1, 0); idle(20);
        // second en during segment 0 chains segment 1 with no gap
        cyc(1, 0); idle(2); cyc(1, 0); idle(20);
        // en held high: back-to-back frames
        for (int i = 0; i < 40; i++) cyc(1, 0);
        idle(20);
        // abort part-way through segment 1, then restart
        cyc(1, 0); idle(10); cyc(1, 0); idle(5); cyc(0, 1); idle(3); cyc(1, 0); idle(20);
        // asynchronous reset mid-segment
        cyc(1, 0); idle(3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_en_mul", int'(em0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_sel", int'(sel0), 0);
        chk("rst_done", int'(done0), 0);
        m0 = mreset(4, 2, 2);
        m1 = mreset(1, 3, 1);
        @(negedge clk);
        rst = 1'b0;
        // abort with en in idle must not start
        cyc(1, 1); idle(2); cyc(1, 0); idle(20);
        for (int i = 0; i < 800; i++)
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0);
        idle(20);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
